motor_cmd_dispatch: RTL

Parametrised UART command parser and dispatcher for N stepper channels. It takes received bytes from the UART receiver and assembles framed commands of the form channel index plus a 32-bit payload. Each command is queued in a per-channel FIFO. A queued command is handed to that channel's motor controller when the controller is idle. The block sits between async_receiver and the motorCtrlSimple_v2 array, and replaces direct register writes with buffered, resynchronising, error-checked dispatch.

---
 rtl/motor_cmd_dispatch.sv | 224 ++++++++++++++++++++++
 1 files changed

// File: rtl/motor_cmd_dispatch.sv
// motor_cmd_dispatch: UART byte-frame parser feeding per-channel command FIFOs and stepper controllers.
// Build macro CMD_CHECKSUM_EN adds a trailing XOR checksum byte to every frame.
module motor_cmd_dispatch #(
    parameter int NUM_CH      = 10,
    parameter int DIV_W       = 15,
    parameter int STEP_W      = 14,
    parameter int FIFO_DEPTH  = 4,
    parameter int TIMEOUT_CYC = 2400
) (
    input  logic                       CLK,
    input  logic                       reset,
    input  logic                       rx_ready,
    input  logic [7:0]                 rx_data,
    input  logic [NUM_CH-1:0]          busy,
    output logic [NUM_CH-1:0]          load,
    output logic [NUM_CH*DIV_W-1:0]    divider,
    output logic [NUM_CH*STEP_W-1:0]   steps_to_go,
    output logic [NUM_CH-1:0]          fifo_full,
    output logic                       frame_ok,
    output logic                       frame_err
);
    localparam int CMD_W = DIV_W + STEP_W;
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int TO_W  = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYC - 1);
    localparam logic [4:0] NUM_CH_L = 5'(NUM_CH);

    typedef enum logic [1:0] {S_IDLE, S_DATA, S_CHECK, S_COMMIT} state_t;
    state_t stateReg, stateNext;

    logic              rxReadyQ;
    logic              byteStb;
    logic [3:0]        chReg;
    logic [31:0]       payloadReg;
    logic [1:0]        byteCntReg;
    logic [TO_W-1:0]   toCntReg;
    logic              inFrame;
    logic              timeoutHit;
    logic              commitAccept;
    logic              frameDrop;
    logic [NUM_CH-1:0] fullVec;
    logic [15:0]       fullPad;
`ifdef CMD_CHECKSUM_EN
    logic [7:0]        xorReg;
`endif

    assign byteStb    = rx_ready & ~rxReadyQ;
    assign inFrame    = (stateReg == S_DATA) || (stateReg == S_CHECK);
    assign timeoutHit = inFrame && (toCntReg == TO_LAST);
    assign fullPad    = 16'(fullVec);
    assign fifo_full  = fullVec;

    always_ff @(posedge CLK) begin
        if (reset) begin
            stateReg <= S_IDLE;
        end else begin
            stateReg <= stateNext;
        end
    end

    // A strobe coinciding with a timeout restarts the parser on that byte.
    always_comb begin
        stateNext = stateReg;
        case (stateReg)
            S_IDLE: begin
                if (byteStb) stateNext = S_DATA;
            end
            S_DATA: begin
                if (timeoutHit) begin
                    stateNext = byteStb ? S_DATA : S_IDLE;
                end else if (byteStb && byteCntReg == 2'd3) begin
`ifdef CMD_CHECKSUM_EN
                    stateNext = S_CHECK;
`else
                    stateNext = S_COMMIT;
`endif
                end
            end
`ifdef CMD_CHECKSUM_EN
            S_CHECK: begin
                if (timeoutHit) begin
                    stateNext = byteStb ? S_DATA : S_IDLE;
                end else if (byteStb) begin
                    stateNext = (rx_data == xorReg) ? S_COMMIT : S_IDLE;
                end
            end
`endif
            S_COMMIT: stateNext = S_IDLE;
            default:  stateNext = S_IDLE;
        endcase
    end

    always_comb begin
        commitAccept = 1'b0;
        frameDrop    = timeoutHit;
        if (stateReg == S_COMMIT) begin
            if (({1'b0, chReg} < NUM_CH_L) && !fullPad[chReg]) begin
                commitAccept = 1'b1;
            end else begin
                frameDrop = 1'b1;
            end
        end
`ifdef CMD_CHECKSUM_EN
        if (stateReg == S_CHECK && !timeoutHit && byteStb && rx_data != xorReg) begin
            frameDrop = 1'b1;
        end
`endif
    end

    always_ff @(posedge CLK) begin
        if (reset) begin
            rxReadyQ   <= 1'b0;
            chReg      <= '0;
            payloadReg <= '0;
            byteCntReg <= '0;
            toCntReg   <= '0;
            frame_ok   <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rxReadyQ  <= rx_ready;
            frame_ok  <= commitAccept;
            frame_err <= frameDrop;
            if (byteStb && (stateReg == S_IDLE || timeoutHit)) begin
                chReg      <= rx_data[3:0];
                payloadReg <= '0;
                byteCntReg <= 2'd0;
            end else if (byteStb && stateReg == S_DATA) begin
                payloadReg <= {rx_data, payloadReg[31:8]};
                byteCntReg <= byteCntReg + 2'd1;
            end
            if (byteStb || !inFrame || timeoutHit) begin
                toCntReg <= '0;
            end else begin
                toCntReg <= toCntReg + TO_W'(1);
            end
        end
    end

`ifdef CMD_CHECKSUM_EN
    always_ff @(posedge CLK) begin
        if (reset) begin
            xorReg <= '0;
        end else if (byteStb && (stateReg == S_IDLE || timeoutHit)) begin
            xorReg <= rx_data;
        end else if (byteStb && stateReg == S_DATA) begin
            xorReg <= xorReg ^ rx_data;
        end
    end
`endif

    genvar gi;
    generate
        for (gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic [CMD_W-1:0]  mem [FIFO_DEPTH];
            logic [PTR_W:0]    wrPtrReg;
            logic [PTR_W:0]    rdPtrReg;
            logic              holdoffReg;
            logic [1:0]        holdCntReg;
            logic              busyQ;
            logic              loadReg;
            logic [DIV_W-1:0]  divReg;
            logic [STEP_W-1:0] stepReg;
            logic              push;
            logic              pop;
            logic              empty;
            logic              full;

            assign empty = (wrPtrReg == rdPtrReg);
            assign full  = (wrPtrReg[PTR_W] != rdPtrReg[PTR_W]) &&
                           (wrPtrReg[PTR_W-1:0] == rdPtrReg[PTR_W-1:0]);
            assign push  = commitAccept && (chReg == 4'(gi));
            assign pop   = !empty && !busy[gi] && !holdoffReg;

            assign fullVec[gi]                        = full;
            assign load[gi]                           = loadReg;
            assign divider[gi*DIV_W +: DIV_W]         = divReg;
            assign steps_to_go[gi*STEP_W +: STEP_W]   = stepReg;

            always_ff @(posedge CLK) begin
                if (push) begin
                    mem[wrPtrReg[PTR_W-1:0]] <= payloadReg[CMD_W-1:0];
                end
            end

            // Holdoff covers the gap until the controller raises activeMode.
            always_ff @(posedge CLK) begin
                if (reset) begin
                    wrPtrReg   <= '0;
                    rdPtrReg   <= '0;
                    holdoffReg <= 1'b0;
                    holdCntReg <= '0;
                    busyQ      <= 1'b0;
                    loadReg    <= 1'b0;
                    divReg     <= '0;
                    stepReg    <= '0;
                end else begin
                    busyQ   <= busy[gi];
                    loadReg <= pop;
                    if (push) begin
                        wrPtrReg <= wrPtrReg + (PTR_W+1)'(1);
                    end
                    if (pop) begin
                        rdPtrReg   <= rdPtrReg + (PTR_W+1)'(1);
                        divReg     <= mem[rdPtrReg[PTR_W-1:0]][DIV_W-1:0];
                        stepReg    <= mem[rdPtrReg[PTR_W-1:0]][CMD_W-1:DIV_W];
                        holdoffReg <= 1'b1;
                        holdCntReg <= '0;
                    end else if (holdoffReg) begin
                        if ((busy[gi] && !busyQ) || holdCntReg == 2'd2) begin
                            holdoffReg <= 1'b0;
                        end else begin
                            holdCntReg <= holdCntReg + 2'd1;
                        end
                    end
                end
            end
        end

        if (CMD_W < 32) begin : g_pad
            logic unusedPayloadHi;
            assign unusedPayloadHi = ^payloadReg[31:CMD_W];
        end
    endgenerate
endmodule
